seq_detect_fsm: RTL and testbench
=================================

Name: seq_detect_fsm

Overview:
- Parametrised serial pattern-detector FSM: next generation of the fixed 4-state Moore controller.
- Watches a gated single-bit input stream for a runtime-loadable PAT_W-bit pattern.
- Selectable overlap and Mealy/Moore output timing; keeps a saturating match counter.
- Sits on a serial control/data path and feeds a one-cycle match strobe to downstream control logic.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, match counter width; legal range 1..32.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match.
- MEALY, 0, 1 = combinational match in the completing cycle; 0 = registered match one cycle later.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- clr, input, 1, synchronous clear of history, fill count, match counter and registered match.
- load, input, 1, capture pattern and enter RUN.
- pattern, input, PAT_W, pattern to detect; bit PAT_W-1 is the first bit received.
- bit_valid, input, 1, bit_in is valid this cycle.
- bit_in, input, 1, serial data bit.
- armed, output, 1, high while state is RUN.
- match, output, 1, one-cycle match strobe.
- match_count, output, CNT_W, saturating count of matches since reset/clr/load.
- count_sat, output, 1, high while match_count equals 2^CNT_W-1.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values: state=IDLE, pat_q=0, hist=0, fill=0, match_q=0, match_count=0. Outputs: armed=0, match=0, count_sat=0.
- States:
  - IDLE: no pattern loaded; bit_valid ignored.
  - RUN: detecting.
  - Transitions: IDLE->RUN on load; RUN->RUN on load (reload). There is no other exit; only reset returns to IDLE.
  - Unreachable state encodings: next-state = X in simulation; synthesis recovers to IDLE.
- load (either state):
  - pat_q <= pattern; hist <= 0; fill <= 0; match_count <= 0; match_q <= 0.
  - A bit_valid in the same cycle is dropped.
- Shift, in RUN with bit_valid=1 and load=0:
  - nhist = {hist[PAT_W-2:0], bit_in}; nfill = min(fill+1, PAT_W).
  - hit = (nhist == pat_q) && (nfill == PAT_W).
- On hit:
  - OVERLAP=1: hist <= nhist, fill <= PAT_W.
  - OVERLAP=0: hist <= 0, fill <= 0.
- On no hit: hist <= nhist, fill <= nfill.
- bit_valid=0 cycles hold hist and fill; gaps do not break a partial match.
- Match output:
  - MEALY=1: match = hit, combinational, in the same cycle as the completing bit.
  - MEALY=0: match_q <= hit; match = match_q, high exactly one cycle after the completing edge. Back-to-back hits give a continuous high.
- Counter: match_count increments on each hit and saturates at 2^CNT_W-1 with no wrap; count_sat = (match_count == all-ones).
- clr:
  - Clears hist, fill, match_count and match_q. State and pat_q are unchanged.
  - A bit in the same cycle is dropped.
  - clr together with load gives the load result.
- Reset asserted mid-stream: all registers go to reset values immediately; a pattern must be reloaded afterwards.
- Width rule: fill is $clog2(PAT_W+1) bits.

Test Plan:
1. PAT_W=4, OVERLAP=1, MEALY=0; load 4'b1011; bits 1,0,1,1,0,1,1 -> match high the cycle after the 4th and after the 7th bit; match_count=2.
2. Same stream with OVERLAP=0 -> single match after the 4th bit; match_count=1.
3. MEALY=1, pattern 4'b1011, bits 1,0,1,1 -> match high in the same cycle as the 4th bit, low otherwise. Insert bit_valid=0 gaps of 3 cycles between bits -> same single match.
4. CNT_W=2, pattern 2'b11, OVERLAP=1, six 1s -> 5 hits, match_count stops at 3, count_sat=1. Then clr -> match_count=0, count_sat=0, armed=1.
5. Bits before any load -> armed=0, no match. load asserted with bit_valid=1 -> that bit is ignored (fill stays 0).
6. Pattern 4'b1011; after bits 1,0,1 assert reset for one cycle -> armed=0, count 0. Reload, send 1 -> no match (history was cleared).

Source files
------------

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: watches a gated bit stream for a loadable PAT_W-bit pattern,
// with selectable overlap and Mealy/Moore match timing plus a saturating match counter.
module seq_detect_fsm #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1,
    parameter int MEALY   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_t;

    state_t            state;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  nhist;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] nfill;
    logic              match_q;
    logic              shift_en;
    logic              hit;

    // load and clr both take priority over an incoming bit, so a bit in those cycles is dropped
    always_comb begin
        shift_en = (state == RUN) && bit_valid && !load && !clr;
        nhist    = {hist[PAT_W-2:0], bit_in};
        nfill    = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
        hit      = shift_en && (nhist == pat_q) && (nfill == FILL_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pat_q       <= '0;
            hist        <= '0;
            fill        <= '0;
            match_q     <= 1'b0;
            match_count <= '0;
        end else begin
            case (state)
                IDLE:    if (load) state <= RUN;
                RUN:     state <= RUN;
`ifndef SYNTHESIS
                default: state <= state_t'(2'bxx);
`else
                default: state <= IDLE;
`endif
            endcase

            if (load) begin
                pat_q       <= pattern;
                hist        <= '0;
                fill        <= '0;
                match_q     <= 1'b0;
                match_count <= '0;
            end else if (clr) begin
                hist        <= '0;
                fill        <= '0;
                match_q     <= 1'b0;
                match_count <= '0;
            end else begin
                match_q <= hit;
                if (shift_en) begin
                    // Without overlap the history restarts so the completing bits cannot be reused
                    if (hit && (OVERLAP == 0)) begin
                        hist <= '0;
                        fill <= '0;
                    end else begin
                        hist <= nhist;
                        fill <= nfill;
                    end
                    if (hit && (match_count != '1))
                        match_count <= match_count + 1'b1;
                end
            end
        end
    end

    assign armed     = (state == RUN);
    assign match     = (MEALY != 0) ? hit : match_q;
    assign count_sat = (match_count == '1);

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: four parameter variants driven from one stream and checked
// against a bit-history reference model, table vectors and hand-written corner sequences.
module tb_seq_detect_fsm;

    logic       clk = 1'b0;
    logic       reset, clr, load, bit_valid, bit_in;
    logic [3:0] pattern;
    logic [3:0] armed_v, match_v, sat_v;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: overlap Moore, B: no-overlap Moore, C: overlap Mealy, D: 2-bit pattern, 2-bit counter
    seq_detect_fsm #(.PAT_W(4), .CNT_W(8), .OVERLAP(1), .MEALY(0)) dut_a (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .pattern(pattern),
        .bit_valid(bit_valid), .bit_in(bit_in), .armed(armed_v[0]), .match(match_v[0]),
        .match_count(cnt_a), .count_sat(sat_v[0]));
    seq_detect_fsm #(.PAT_W(4), .CNT_W(8), .OVERLAP(0), .MEALY(0)) dut_b (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .pattern(pattern),
        .bit_valid(bit_valid), .bit_in(bit_in), .armed(armed_v[1]), .match(match_v[1]),
        .match_count(cnt_b), .count_sat(sat_v[1]));
    seq_detect_fsm #(.PAT_W(4), .CNT_W(8), .OVERLAP(1), .MEALY(1)) dut_c (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .pattern(pattern),
        .bit_valid(bit_valid), .bit_in(bit_in), .armed(armed_v[2]), .match(match_v[2]),
        .match_count(cnt_c), .count_sat(sat_v[2]));
    seq_detect_fsm #(.PAT_W(2), .CNT_W(2), .OVERLAP(1), .MEALY(0)) dut_d (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .pattern(pattern[1:0]),
        .bit_valid(bit_valid), .bit_in(bit_in), .armed(armed_v[3]), .match(match_v[3]),
        .match_count(cnt_d), .count_sat(sat_v[3]));

    int m_w[4]     = '{4, 4, 4, 2};
    int m_ov[4]    = '{1, 0, 1, 1};
    int m_mealy[4] = '{0, 0, 1, 0};
    int m_cw[4]    = '{8, 8, 8, 2};

    // Model state: the raw list of bits accepted since the last restart of the history
    bit     m_armed[4];
    int     m_pat[4];
    int     m_hbuf[4][64];
    int     m_hlen[4];
    longint m_cnt[4];
    bit     m_mq[4];
    bit     m_hit[4];

    function automatic longint getCnt(int i);
        case (i)
            0:       return longint'(cnt_a);
            1:       return longint'(cnt_b);
            2:       return longint'(cnt_c);
            default: return longint'(cnt_d);
        endcase
    endfunction

    function automatic bit tailMatches(int i, int extra_bit);
        int n;
        int v;
        int b;
        n = m_hlen[i] + 1;
        if (n < m_w[i]) return 1'b0;
        v = 0;
        for (int k = n - m_w[i]; k < n; k++) begin
            b = (k == n - 1) ? extra_bit : m_hbuf[i][k];
            v = v * 2 + b;
        end
        return v == m_pat[i];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_armed[i] = 1'b0;
            m_pat[i]   = 0;
            m_hlen[i]  = 0;
            m_cnt[i]   = 0;
            m_mq[i]    = 1'b0;
            m_hit[i]   = 1'b0;
        end
    endtask

    task automatic computeHits();
        for (int i = 0; i < 4; i++)
            m_hit[i] = !reset && m_armed[i] && bit_valid && !load && !clr && tailMatches(i, int'(bit_in));
    endtask

    task automatic modelStep();
        if (reset) begin
            modelReset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (load) begin
                m_armed[i] = 1'b1;
                m_pat[i]   = int'(pattern) & ((1 << m_w[i]) - 1);
                m_hlen[i]  = 0;
                m_cnt[i]   = 0;
                m_mq[i]    = 1'b0;
            end else if (clr) begin
                m_hlen[i] = 0;
                m_cnt[i]  = 0;
                m_mq[i]   = 1'b0;
            end else begin
                m_mq[i] = m_hit[i];
                if (m_armed[i] && bit_valid) begin
                    if (m_hlen[i] == 64) begin
                        for (int k = 0; k < 32; k++) m_hbuf[i][k] = m_hbuf[i][k+32];
                        m_hlen[i] = 32;
                    end
                    m_hbuf[i][m_hlen[i]] = int'(bit_in);
                    m_hlen[i]++;
                    if (m_hit[i]) begin
                        if (m_cnt[i] < (64'sd1 << m_cw[i]) - 1) m_cnt[i]++;
                        if (m_ov[i] == 0) m_hlen[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic checkVal(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("model inst%0d armed", i), longint'(armed_v[i]), longint'(m_armed[i]));
            checkVal($sformatf("model inst%0d match", i), longint'(match_v[i]),
                     longint'(m_mealy[i] != 0 ? m_hit[i] : m_mq[i]));
            checkVal($sformatf("model inst%0d count", i), getCnt(i), m_cnt[i]);
            checkVal($sformatf("model inst%0d count_sat", i), longint'(sat_v[i]),
                     longint'(m_cnt[i] == (64'sd1 << m_cw[i]) - 1));
        end
    endtask

    // One clock cycle; mealy_now is the Mealy instance's match sampled before the edge
    task automatic applyStimulus(input logic r, input logic c, input logic l, input logic [3:0] p,
                                 input logic bv, input logic b, output logic mealy_now);
        @(negedge clk);
        reset     = r;
        clr       = c;
        load      = l;
        pattern   = p;
        bit_valid = bv;
        bit_in    = b;
        if (r) modelReset();
        #1;
        computeHits();
        mealy_now = match_v[2];
        checkOutput();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    typedef struct {
        logic       r, c, l;
        logic [3:0] p;
        logic       bv, b;
        logic       exp_match_a;
        int         exp_cnt_a;
        logic       exp_match_b;
        int         exp_cnt_b;
    } vec_t;

    vec_t tbl[9];
    logic mn;
    int   stream[4] = '{1, 0, 1, 1};

    initial begin
        reset = 1'b1; clr = 1'b0; load = 1'b0; pattern = 4'd0; bit_valid = 1'b0; bit_in = 1'b0;
        modelReset();

        tbl[0] = '{1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1};

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mn);
        checkVal("reset armed", longint'(armed_v), 0);
        checkVal("reset match", longint'(match_v), 0);
        checkVal("reset count_a", longint'(cnt_a), 0);
        checkVal("reset count_sat", longint'(sat_v), 0);

        // Bits before any load are ignored
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, mn);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, mn);
        checkVal("idle armed", longint'(armed_v), 0);
        checkVal("idle match", longint'(match_v), 0);
        checkVal("idle count_d", longint'(cnt_d), 0);

        // Overlap vs no-overlap on 1,0,1,1,0,1,1
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].p, tbl[i].bv, tbl[i].b, mn);
            checkVal($sformatf("tbl%0d match_a", i), longint'(match_v[0]), longint'(tbl[i].exp_match_a));
            checkVal($sformatf("tbl%0d count_a", i), longint'(cnt_a), longint'(tbl[i].exp_cnt_a));
            checkVal($sformatf("tbl%0d match_b", i), longint'(match_v[1]), longint'(tbl[i].exp_match_b));
            checkVal($sformatf("tbl%0d count_b", i), longint'(cnt_b), longint'(tbl[i].exp_cnt_b));
        end

        // Mealy timing with three idle cycles between bits
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, mn);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, stream[k][0], mn);
            checkVal($sformatf("mealy bit%0d", k), longint'(mn), (k == 3) ? 1 : 0);
            for (int g = 0; g < 3; g++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b1, mn);
                checkVal($sformatf("mealy gap%0d_%0d", k, g), longint'(mn), 0);
            end
        end
        checkVal("mealy count_c", longint'(cnt_c), 1);
        checkVal("gapped count_a", longint'(cnt_a), 1);

        // Counter saturation on the 2-bit instance: six 1s against pattern 11
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, mn);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, mn);
        checkVal("sat count_d", longint'(cnt_d), 3);
        checkVal("sat count_sat_d", longint'(sat_v[3]), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b1011, 1'b1, 1'b1, mn);
        checkVal("clr count_d", longint'(cnt_d), 0);
        checkVal("clr count_sat_d", longint'(sat_v[3]), 0);
        checkVal("clr armed_d", longint'(armed_v[3]), 1);

        // A bit presented with load is dropped
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, mn);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, mn);
        checkVal("load-drop match_d", longint'(match_v[3]), 0);
        checkVal("load-drop count_d", longint'(cnt_d), 0);

        // Reset mid-pattern, then reload: history must be gone
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, mn);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, stream[k][0], mn);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1011, 1'b0, 1'b0, mn);
        checkVal("midreset armed_a", longint'(armed_v[0]), 0);
        checkVal("midreset count_a", longint'(cnt_a), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, mn);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, mn);
        checkVal("reload match_a", longint'(match_v[0]), 0);
        checkVal("reload count_a", longint'(cnt_a), 0);

        // Randomized traffic against the model
        applyStimulus(1'b0, 1'b0, 1'b1, 4'($urandom), 1'b0, 1'b0, mn);
        for (int k = 0; k < 800; k++) begin
            applyStimulus(($urandom % 150) == 0, ($urandom % 60) == 0, ($urandom % 45) == 0,
                          4'($urandom), ($urandom % 4) != 0, 1'($urandom), mn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
